// File: rtl/segre_mem_arbiter_if.sv
// Main-memory line bus between segre_mem_arbiter (master) and the memory controller (slave).
interface segre_mem_arbiter_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int LINE_BYTES = 16
);
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [ADDR_SIZE-1:0]    mem_addr_o;
  logic [LINE_BYTES*8-1:0] mem_wdata_o;
  logic [LINE_BYTES*8-1:0] mem_rdata_i;
  logic                    mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/segre_mem_arbiter.sv
// Single-port memory arbiter for I$ line fills and D$ fills/writebacks, one line in flight.
// Optional macro SEGRE_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data-first.
module segre_mem_arbiter #(
  parameter int ADDR_SIZE      = 32,
  parameter int LINE_BYTES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    ifetch_rd_i,
  input  logic [ADDR_SIZE-1:0]    ifetch_addr_i,
  output logic [LINE_BYTES*8-1:0] ifetch_line_o,
  output logic                    ifetch_ready_o,
  input  logic                    dmem_rd_i,
  input  logic                    dmem_wr_i,
  input  logic [ADDR_SIZE-1:0]    dmem_addr_i,
  input  logic [LINE_BYTES*8-1:0] dmem_line_i,
  output logic [LINE_BYTES*8-1:0] dmem_line_o,
  output logic                    dmem_ready_o,
  segre_mem_arbiter_if.master     mem_if,
  output logic                    mem_timeout_o
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_SIZE-1:0] OFF_MASK = ADDR_SIZE'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;   // 1: data side owns the transaction
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [LINE_W-1:0]     iline_q, iline_d;
  logic [LINE_W-1:0]     dline_q, dline_d;
  logic                  irdy_q, irdy_d;
  logic                  drdy_q, drdy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tout_q, tout_d;
  logic                  data_req;
  logic                  grant_data;

  function automatic logic [ADDR_SIZE-1:0] line_align(input logic [ADDR_SIZE-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  assign data_req = dmem_rd_i | dmem_wr_i;

`ifdef SEGRE_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;   // 1: data side was granted last
  assign grant_data = data_req & (~ifetch_rd_i | ~last_q);
`else
  assign grant_data = data_req;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    iline_d = iline_q;
    dline_d = dline_q;
    irdy_d  = 1'b0;
    drdy_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_req || ifetch_rd_i) begin
          state_d = ISSUE;
          req_d   = 1'b1;
          owner_d = grant_data;
          cnt_d   = '0;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
          last_d  = grant_data;
`endif
          if (grant_data) begin
            // a pending writeback goes before the fill of the same requester
            we_d    = dmem_wr_i;
            addr_d  = line_align(dmem_addr_i);
            wdata_d = dmem_wr_i ? dmem_line_i : '0;
          end else begin
            we_d    = 1'b0;
            addr_d  = line_align(ifetch_addr_i);
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_if.mem_ack_i) begin
          state_d = RESP;
          req_d   = 1'b0;
          if (owner_q) drdy_d = 1'b1;
          else         irdy_d = 1'b1;
          if (!we_q) begin
            if (owner_q) dline_d = mem_if.mem_rdata_i;
            else         iline_d = mem_if.mem_rdata_i;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tout_d = tout_q | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      iline_q <= '0;
      dline_q <= '0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      iline_q <= iline_d;
      dline_q <= dline_d;
      irdy_q  <= irdy_d;
      drdy_q  <= drdy_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign mem_if.mem_req_o   = req_q;
  assign mem_if.mem_we_o    = we_q;
  assign mem_if.mem_addr_o  = addr_q;
  assign mem_if.mem_wdata_o = wdata_q;
  assign ifetch_line_o      = iline_q;
  assign ifetch_ready_o     = irdy_q;
  assign dmem_line_o        = dline_q;
  assign dmem_ready_o       = drdy_q;
  assign mem_timeout_o      = tout_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Randomized bench for segre_mem_arbiter: bench acts as memory and requesters, checks against a
// transaction-level service-order model.
module tb_segre_mem_arbiter;
  localparam int AW = 32;
  localparam int LB = 16;
  localparam int LW = LB * 8;
  localparam int TO = 255;
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rsn_i = 1'b0;
  logic          ifetch_rd_i = 1'b0;
  logic [AW-1:0] ifetch_addr_i = '0;
  logic [LW-1:0] ifetch_line_o;
  logic          ifetch_ready_o;
  logic          dmem_rd_i = 1'b0;
  logic          dmem_wr_i = 1'b0;
  logic [AW-1:0] dmem_addr_i = '0;
  logic [LW-1:0] dmem_line_i = '0;
  logic [LW-1:0] dmem_line_o;
  logic          dmem_ready_o;
  logic          mem_timeout_o;

  segre_mem_arbiter_if #(.ADDR_SIZE(AW), .LINE_BYTES(LB)) mif ();

  segre_mem_arbiter #(.ADDR_SIZE(AW), .LINE_BYTES(LB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .ifetch_rd_i    (ifetch_rd_i),
    .ifetch_addr_i  (ifetch_addr_i),
    .ifetch_line_o  (ifetch_line_o),
    .ifetch_ready_o (ifetch_ready_o),
    .dmem_rd_i      (dmem_rd_i),
    .dmem_wr_i      (dmem_wr_i),
    .dmem_addr_i    (dmem_addr_i),
    .dmem_line_i    (dmem_line_i),
    .dmem_line_o    (dmem_line_o),
    .dmem_ready_o   (dmem_ready_o),
    .mem_if         (mif),
    .mem_timeout_o  (mem_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic we; logic [AW-1:0] addr; logic [LW-1:0] wdata; logic [LW-1:0] rdata;
                   int req_tick; int ack_tick; } tx_t;
  typedef struct { bit data_side; logic [LW-1:0] line; int tick; } rdy_t;
  typedef struct { bit data_side; bit we; logic [AW-1:0] addr; logic [LW-1:0] wdata; } exp_t;

  tx_t  txq[$];
  rdy_t rq[$];
  exp_t expq[$];

  int total = 0;
  int bad = 0;
  int tick_n = 0;
  int to_tick = -1;
  int ack_delay = 0;
  int wait_n = 0;
  int req_tick_cur = 0;
  bit busy = 1'b0;
  bit scramble = 1'b0;
  bit last_data = 1'b0;
  logic [LW-1:0] exp_iline = '0;
  logic [LW-1:0] exp_dline = '0;

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: observe ready pulses, play requester and memory roles.
  task automatic tick();
    tx_t  t;
    rdy_t r;
    @(posedge clk_i);
    #1;
    tick_n++;
    if (ifetch_ready_o) begin
      r.data_side = 1'b0; r.line = ifetch_line_o; r.tick = tick_n;
      rq.push_back(r);
      ifetch_rd_i = 1'b0;
    end
    if (dmem_ready_o) begin
      r.data_side = 1'b1; r.line = dmem_line_o; r.tick = tick_n;
      rq.push_back(r);
      if (dmem_wr_i) dmem_wr_i = 1'b0;
      else           dmem_rd_i = 1'b0;
    end
    if (mem_timeout_o && to_tick < 0) to_tick = tick_n;
    if (mif.mem_ack_i) begin
      mif.mem_ack_i = 1'b0;
    end else if (mif.mem_req_o) begin
      if (!busy) begin
        busy = 1'b1; wait_n = 0; req_tick_cur = tick_n;
      end else begin
        wait_n++;
      end
      if (wait_n >= ack_delay) begin
        t.rdata = rnd_line();
        t.we = mif.mem_we_o; t.addr = mif.mem_addr_o; t.wdata = mif.mem_wdata_o;
        t.req_tick = req_tick_cur; t.ack_tick = tick_n;
        txq.push_back(t);
        mif.mem_rdata_i = t.rdata;
        mif.mem_ack_i = 1'b1;
        busy = 1'b0;
      end
    end
    if (scramble) begin
      ifetch_addr_i = $urandom; dmem_addr_i = $urandom; dmem_line_i = rnd_line();
    end
  endtask

  task automatic run_scn(input bit f, input bit dr, input bit dw, input logic [AW-1:0] fa,
                         input logic [AW-1:0] da, input logic [LW-1:0] wl, input int dly,
                         input bit drop, input string name);
    bit pf, pr, pw, take_data;
    exp_t e;
    int raise_tick, budget;
    pf = f; pr = dr; pw = dw;
    expq.delete();
    while (pf || pr || pw) begin
      if ((pr || pw) && pf) take_data = RR ? !last_data : 1'b1;
      else                  take_data = pr || pw;
      if (take_data) begin
        e.data_side = 1'b1; e.addr = da - (da % LB);
        if (pw) begin e.we = 1'b1; e.wdata = wl; pw = 1'b0; end
        else    begin e.we = 1'b0; e.wdata = '0; pr = 1'b0; end
      end else begin
        e.data_side = 1'b0; e.we = 1'b0; e.addr = fa - (fa % LB); e.wdata = '0; pf = 1'b0;
      end
      last_data = take_data;
      expq.push_back(e);
    end
    txq.delete(); rq.delete();
    ack_delay = dly;
    ifetch_addr_i = fa; dmem_addr_i = da; dmem_line_i = wl;
    ifetch_rd_i = f; dmem_rd_i = dr; dmem_wr_i = dw;
    raise_tick = tick_n;
    budget = expq.size() * (dly + 8) + 10;
    for (int c = 0; c < budget && rq.size() < expq.size(); c++) begin
      tick();
      if (drop && c == 0) begin
        ifetch_rd_i = 1'b0; dmem_rd_i = 1'b0; dmem_wr_i = 1'b0; scramble = 1'b1;
      end
    end
    scramble = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    check_eq({name, ".ntx"}, txq.size(), expq.size());
    check_eq({name, ".nrdy"}, rq.size(), expq.size());
    for (int k = 0; k < expq.size() && k < txq.size() && k < rq.size(); k++) begin
      check_eq({name, ".we"}, txq[k].we, expq[k].we);
      check_eq({name, ".addr"}, txq[k].addr, expq[k].addr);
      check_eq({name, ".wdata"}, txq[k].wdata, expq[k].wdata);
      check_eq({name, ".side"}, rq[k].data_side, expq[k].data_side);
      check_eq({name, ".rdylat"}, rq[k].tick, txq[k].ack_tick + 1);
      check_eq({name, ".reqlat"}, txq[k].req_tick, (k == 0) ? raise_tick + 1 : rq[k-1].tick + 2);
      if (!expq[k].we) begin
        check_eq({name, ".line"}, rq[k].line, txq[k].rdata);
        if (expq[k].data_side) exp_dline = txq[k].rdata;
        else                   exp_iline = txq[k].rdata;
      end
    end
    check_eq({name, ".iline"}, ifetch_line_o, exp_iline);
    check_eq({name, ".dline"}, dmem_line_o, exp_dline);
  endtask

  initial begin
    bit f, dr, dw, drop;
    mif.mem_ack_i = 1'b0;
    mif.mem_rdata_i = '0;
    for (int c = 0; c < 3; c++) tick();
    check_eq("rst.req", mif.mem_req_o, 0);
    check_eq("rst.addr", mif.mem_addr_o, 0);
    check_eq("rst.iline", ifetch_line_o, 0);
    check_eq("rst.dline", dmem_line_o, 0);
    check_eq("rst.rdy", {ifetch_ready_o, dmem_ready_o}, 0);
    check_eq("rst.tmo", mem_timeout_o, 0);
    rsn_i = 1'b1;
    for (int c = 0; c < 2; c++) tick();

    run_scn(1, 0, 0, 32'h0000_0104, '0, '0, 3, 0, "fetch104");
    run_scn(0, 1, 1, '0, 32'h0000_0080, {16{8'hA5}}, 2, 0, "wr_rd80");
    run_scn(1, 1, 0, $urandom, $urandom, '0, 1, 0, "contend_a");
    run_scn(1, 1, 0, $urandom, $urandom, '0, 0, 0, "contend_b");
    run_scn(1, 0, 0, $urandom, '0, '0, 4, 1, "drop_fetch");
    run_scn(0, 0, 1, '0, $urandom, rnd_line(), 3, 1, "drop_wr");

    for (int i = 0; i < 30; i++) begin
      f = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      if (!(f || dr || dw)) f = 1'b1;
      drop = (int'(f) + int'(dr) + int'(dw) == 1) && ($urandom_range(0, 3) == 0);
      run_scn(f, dr, dw, $urandom, $urandom, rnd_line(), $urandom_range(0, 4), drop, "rand");
    end

    check_eq("tmo.before", mem_timeout_o, 0);
    run_scn(1, 0, 0, $urandom, '0, '0, 260, 0, "tmo");
    if (txq.size() > 0) check_eq("tmo.rise", to_tick - txq[0].req_tick, TO);
    check_eq("tmo.sticky", mem_timeout_o, 1);

    ack_delay = 50;
    ifetch_addr_i = $urandom;
    ifetch_rd_i = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    check_eq("mid.req", mif.mem_req_o, 1);
    #2 rsn_i = 1'b0;
    #1;
    check_eq("arst.req", mif.mem_req_o, 0);
    check_eq("arst.we", mif.mem_we_o, 0);
    check_eq("arst.addr", mif.mem_addr_o, 0);
    check_eq("arst.wdata", mif.mem_wdata_o, 0);
    check_eq("arst.iline", ifetch_line_o, 0);
    check_eq("arst.dline", dmem_line_o, 0);
    check_eq("arst.rdy", {ifetch_ready_o, dmem_ready_o}, 0);
    check_eq("arst.tmo", mem_timeout_o, 0);
    ifetch_rd_i = 1'b0;
    busy = 1'b0;
    exp_iline = '0; exp_dline = '0; last_data = 1'b0;
    for (int c = 0; c < 2; c++) tick();
    rsn_i = 1'b1;
    rq.delete(); txq.delete();
    mif.mem_rdata_i = rnd_line();
    mif.mem_ack_i = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check_eq("stray_ack.rdy", rq.size(), 0);
    check_eq("stray_ack.req", mif.mem_req_o, 0);
    check_eq("stray_ack.iline", ifetch_line_o, 0);

    run_scn(1, 1, 0, $urandom, $urandom, '0, 2, 0, "post_rst");
    run_scn(1, 1, 1, $urandom, $urandom, rnd_line(), 1, 0, "post_rst3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Arbitrates the single main-memory port between the instruction-cache miss path and the data-cache miss/writeback path. Each request is a whole cache line, and one transaction is in flight at a time. Read data returns as a registered cache line with a one-cycle ready pulse. The fetch-side outputs drive the fetch stage's `cache_instr_line_i`/`mem_ready_i` directly.

## Interface
- `ADDR_SIZE`, 32, byte address width
- `LINE_BYTES`, 16, cache line size in bytes (power of two, ≥4)
- `TIMEOUT_CYCLES`, 255, cycles in ISSUE before `mem_timeout_o` sets (≥1)
- `clk_i` in 1: single clock
- `rsn_i` in 1: reset, asynchronous, active-low
- `ifetch_rd_i` in 1: fetch-side line read request (level)
- `ifetch_addr_i` in ADDR_SIZE: fetch-side byte address
- `ifetch_line_o` out LINE_BYTES×8: fetched line
- `ifetch_ready_o` out 1: one-cycle completion pulse, fetch side
- `dmem_rd_i` in 1: data-side line read (fill) request
- `dmem_wr_i` in 1: data-side line writeback request
- `dmem_addr_i` in ADDR_SIZE: data-side byte address
- `dmem_line_i` in LINE_BYTES×8: writeback line
- `dmem_line_o` out LINE_BYTES×8: filled line
- `dmem_ready_o` out 1: one-cycle completion pulse, data side
- `mem_req_o` out 1: memory request, held until ack
- `mem_we_o` out 1: 1 = write, 0 = read
- `mem_addr_o` out ADDR_SIZE: line-aligned address (low log2(LINE_BYTES) bits zero)
- `mem_wdata_o` out LINE_BYTES×8: write line
- `mem_rdata_i` in LINE_BYTES×8: read line, valid with ack
- `mem_ack_i` in 1: memory completion
- `mem_timeout_o` out 1: sticky, set when an ISSUE exceeds TIMEOUT_CYCLES

## Operation
- FSM states and transitions:
  - **IDLE:** leaves to ISSUE on any pending request; otherwise stays in IDLE.
  - **ISSUE:** drives the memory request; leaves to RESP on `mem_ack_i`.
  - **RESP:** pulses ready to the granted requester, then returns to IDLE unconditionally.
- Grant decision in IDLE: the data side has priority over fetch (see Configuration).
- Within the data side, `dmem_wr_i` beats `dmem_rd_i` when both are high. The requester keeps `dmem_rd_i` high, and the fill is served as the next transaction.
- On entry to ISSUE the following are registered and held constant until ack, regardless of later requester input changes:
  - grant owner
  - `mem_we_o`
  - `mem_addr_o`
  - `mem_wdata_o` (zero for reads)
- A request dropped mid-transaction still completes, and the ready pulse is still issued.
- Ack on a read: `mem_rdata_i` is captured into the owner's line register. The other side's line register is unchanged.
- Ack on a write: no line register changes, and the ready pulse is still issued.
- Line outputs hold their value until the next capture for that side.
- Requesters must deassert a served request the cycle after their ready pulse. A request still high in IDLE is treated as new.
- Wait counter:
  - clears on entry to ISSUE and increments each ISSUE cycle without ack, saturating.
  - `mem_timeout_o` sets when the counter reaches TIMEOUT_CYCLES and stays set until reset. The FSM keeps waiting.
- `mem_ack_i` outside ISSUE is ignored.
- Reset (async, any state):
  - FSM returns to IDLE and any in-flight transaction is dropped.
  - Zero: all outputs, line registers, counter, and round-robin pointer.

## Timing
- Request sampled in IDLE at cycle N → `mem_req_o`=1 from N+1.
- Ack at cycle M (M ≥ N+1) → ready pulse and valid line at M+1; `mem_req_o`=0 at M+1.
- Minimum turnaround: 2 cycles from request to ready. Back-to-back transactions are spaced by one IDLE cycle.
- `mem_*` outputs and ready pulses are all registered; no combinational input→output paths.

## Configuration
- `SEGRE_ARB_ROUND_ROBIN_EN`:
  - **Defined:** when both sides request in the same IDLE cycle, the grant goes to the side not served last. A one-bit last-grant pointer updates on each grant and resets to "fetch served last".
  - **Undefined:** fixed priority; the data side always wins.

## Test plan
- Fetch read, addr 0x0000_0104, memory acks 3 cycles after `mem_req_o` → `mem_addr_o`=0x0000_0100, `mem_we_o`=0, `ifetch_ready_o` pulses once and `ifetch_line_o` equals the returned line; `dmem_line_o` stays 0.
- Simultaneous `dmem_wr_i`+`dmem_rd_i` at 0x80 with line 0xA5…A5 → write issued first with `mem_wdata_o`=0xA5…A5, then ready, then the read at 0x80 → second ready with the read line.
- Fetch and data read in the same cycle, both back-to-back:
  - Macro undefined: data served, then fetch.
  - Macro defined: data served first (pointer at reset = fetch last), then fetch; the next contention goes to data.
- Ack withheld 260 cycles with TIMEOUT_CYCLES=255 → `mem_timeout_o` rises after 255 ISSUE cycles and stays 1 after the eventual ack/ready.
- `rsn_i` low mid-ISSUE → `mem_req_o` and all outputs 0 immediately; a later ack is ignored and no ready pulse follows.
- Fetch request dropped one cycle after grant → transaction completes and `ifetch_ready_o` still pulses once.
